// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU command sequencer.
// The FIFO entry carries a use_acc flag only when ALU_SEQ_ACC_EN is defined.
package alu_seq_pkg;

  localparam int WIDTH = 5;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef ALU_SEQ_ACC_EN
    logic             use_acc;
`endif
  } fifo_entry_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command and result handshake bundle of the ALU sequencer.
// cmd_use_acc exists only when ALU_SEQ_ACC_EN is defined.
interface alu_op_sequencer_if;
  import alu_seq_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
`ifdef ALU_SEQ_ACC_EN
  logic             cmd_use_acc;
`endif
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [1:0]       res_op;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
`ifdef ALU_SEQ_ACC_EN
    output cmd_use_acc,
`endif
    output res_ready,
    input  cmd_ready, res_valid, res_data, res_op
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
`ifdef ALU_SEQ_ACC_EN
    input  cmd_use_acc,
`endif
    input  res_ready,
    output cmd_ready, res_valid, res_data, res_op
  );

endinterface

// File: rtl/alu_op_sequencer_fifo.sv
// alu_cmd_fifo: synchronous power-of-two FIFO with wrap-bit pointers, no bypass.
module alu_cmd_fifo import alu_seq_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  fifo_entry_t entry_i,
  input  logic        pop_i,
  output fifo_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  fifo_entry_t mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic        do_push_s, do_pop_s;

  // Equal index with differing wrap bits means the writer lapped the reader.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  // Pointer advance, gated so overflow/underflow requests are ignored.
  always_comb begin
    do_push_s = push_i && !full_o;
    do_pop_s  = pop_i && !empty_o;
    wr_d      = do_push_s ? (wr_q + PTR_ONE) : wr_q;
    rd_d      = do_pop_s  ? (rd_q + PTR_ONE) : rd_q;
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= {(AW+1){1'b0}};
      rd_q <= {(AW+1){1'b0}};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_q[AW-1:0]] <= entry_i;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU commands, issues them one at a time, registers results.
// Define ALU_SEQ_ACC_EN to add an accumulator usable as operand B.
module alu_op_sequencer import alu_seq_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  alu_op_sequencer_if.slave bus,
  output logic [1:0]        alu_sel,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_sum,
  output logic              busy
);

  state_e           state_q, state_d;
  logic             pop_s, push_s, full_s, empty_s;
  fifo_entry_t      push_entry_s, head_s;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic [1:0]       res_op_q, res_op_d;
`ifdef ALU_SEQ_ACC_EN
  logic [WIDTH-1:0] acc_q, acc_d;
`endif

  // Command capture into the FIFO entry format.
  always_comb begin
    push_s          = bus.cmd_valid && !full_s;
    push_entry_s.op = bus.cmd_op;
    push_entry_s.a  = bus.cmd_a;
    push_entry_s.b  = bus.cmd_b;
`ifdef ALU_SEQ_ACC_EN
    push_entry_s.use_acc = bus.cmd_use_acc;
`endif
  end

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .entry_i (push_entry_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Issue FSM: next state, pop request and result capture.
  always_comb begin
    state_d     = state_q;
    pop_s       = 1'b0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
`ifdef ALU_SEQ_ACC_EN
    acc_d       = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        res_valid_d = 1'b1;
        res_data_d  = alu_sum;
        res_op_d    = sel_q;
`ifdef ALU_SEQ_ACC_EN
        acc_d       = alu_sum;
`endif
        state_d     = HOLD;
      end
      HOLD: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          if (!empty_s) begin
            pop_s   = 1'b1;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // Operand registers move only on a pop; the accumulator is current because issue is serial.
  always_comb begin
    sel_d = pop_s ? head_s.op : sel_q;
    a_d   = pop_s ? head_s.a  : a_q;
`ifdef ALU_SEQ_ACC_EN
    b_d   = pop_s ? (head_s.use_acc ? acc_q : head_s.b) : b_q;
`else
    b_d   = pop_s ? head_s.b : b_q;
`endif
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= 2'b00;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      res_valid_q <= 1'b0;
      res_data_q  <= {WIDTH{1'b0}};
      res_op_q    <= 2'b00;
`ifdef ALU_SEQ_ACC_EN
      acc_q       <= {WIDTH{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
`ifdef ALU_SEQ_ACC_EN
      acc_q       <= acc_d;
`endif
    end
  end

  assign alu_sel       = sel_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_op    = res_op_q;
  assign bus.cmd_ready = !full_s;
  assign busy          = (state_q != IDLE) || !empty_s;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: vector table, corner sequences, random run vs. a queue model.
// Works with or without ALU_SEQ_ACC_EN defined.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       alu_sel;
  logic [WIDTH-1:0] alu_a, alu_b, alu_sum;
  logic             busy;

  alu_op_sequencer_if bus();

  alu_op_sequencer #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .alu_sel (alu_sel),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sum (alu_sum),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the downstream ALU stage.
  always_comb begin
    case (alu_sel)
      2'b00:   alu_sum = alu_a & alu_b;
      2'b01:   alu_sum = alu_a + alu_b;
      2'b10:   alu_sum = alu_a | alu_b;
      default: alu_sum = alu_a ^ alu_b;
    endcase
  end

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int n_acc  = 0;
  int last_del_cyc = 0;
  int del_gap = 0;
  int macc = 0;
  int exp_q[$];
  int expop_q[$];
  int got_q[$];

  typedef struct {
    int op;
    int a;
    int b;
    int exp;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int ref_alu(input int op, input int a, input int b);
    case (op)
      0:       return a & b;
      1:       return (a + b) % 32;
      2:       return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic set_cmd(input int op, input int a, input int b, input int ua);
    bus.cmd_op = 2'(op);
    bus.cmd_a  = 5'(a);
    bus.cmd_b  = 5'(b);
`ifdef ALU_SEQ_ACC_EN
    bus.cmd_use_acc = (ua != 0);
`else
    if (ua != 0) bus.cmd_op = 2'(op);
`endif
  endtask

  task automatic rand_cmd();
    set_cmd($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1));
  endtask

  // One clock: scoreboard both handshakes as they occur at the coming edge.
  task automatic tick();
    bit acc_now, del_now;
    int bb;
    acc_now = bus.cmd_valid && bus.cmd_ready;
    del_now = bus.res_valid && bus.res_ready;
    if (del_now) begin
      chk("sb_has_entry", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        chk("res_data", int'(bus.res_data), exp_q.pop_front());
        chk("res_op", int'(bus.res_op), expop_q.pop_front());
      end
      got_q.push_back(int'(bus.res_data));
      del_gap = cyc - last_del_cyc;
      last_del_cyc = cyc;
    end
    if (acc_now) begin
      bb = int'(bus.cmd_b);
`ifdef ALU_SEQ_ACC_EN
      if (bus.cmd_use_acc) bb = macc;
`endif
      macc = ref_alu(int'(bus.cmd_op), int'(bus.cmd_a), bb);
      exp_q.push_back(macc);
      expop_q.push_back(int'(bus.cmd_op));
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;
    exp_q.delete();
    expop_q.delete();
    macc = 0;
  endtask

  task automatic drain(input int limit);
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < limit && exp_q.size() > 0; i++) tick();
    chk("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1, 20, 15, 3};
    tbl[1] = '{0, 22, 12, 4};
    tbl[2] = '{3, 22, 12, 26};
    tbl[3] = '{2, 22, 12, 30};
    tbl[4] = '{1, 31, 31, 30};
    tbl[5] = '{1, 0, 0, 0};
    tbl[6] = '{0, 31, 31, 31};
    tbl[7] = '{3, 31, 31, 0};

    set_cmd(0, 0, 0, 0);
    do_reset();
    do_reset();
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_res_data", int'(bus.res_data), 0);
    chk("rst_res_op", int'(bus.res_op), 0);
    chk("rst_cmd_ready", int'(bus.cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_alu_sel", int'(alu_sel), 0);
    chk("rst_alu_ab", int'({alu_a, alu_b}), 0);

    // Single commands: valid exactly two edges after acceptance.
    bus.res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_cmd(tbl[i].op, tbl[i].a, tbl[i].b, 0);
      bus.cmd_valid = 1'b1;
      chk("vec_cmd_ready", int'(bus.cmd_ready), 1);
      tick();
      bus.cmd_valid = 1'b0;
      chk("vec_lat_n0", int'(bus.res_valid), 0);
      tick();
      chk("vec_lat_n1", int'(bus.res_valid), 0);
      tick();
      chk("vec_valid_n2", int'(bus.res_valid), 1);
      chk("vec_data", int'(bus.res_data), tbl[i].exp);
      chk("vec_op", int'(bus.res_op), tbl[i].op);
      tick();
      chk("vec_busy_after", int'(busy), 0);
    end

    // AND then XOR back-to-back: one result per two cycles.
    got_q.delete();
    set_cmd(0, 22, 12, 0);
    bus.cmd_valid = 1'b1;
    tick();
    set_cmd(3, 22, 12, 0);
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 20 && got_q.size() < 2; i++) tick();
    chk("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("b2b_and", got_q[0], 4);
      chk("b2b_xor", got_q[1], 26);
      chk("b2b_gap", del_gap, 2);
    end

    // Backpressure: DEPTH in the FIFO plus one in flight.
    bus.res_ready = 1'b0;
    n_acc = 0;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_cmd();
      tick();
    end
    bus.cmd_valid = 1'b0;
    chk("bp_accepted", n_acc, DEPTH + 1);
    chk("bp_cmd_ready", int'(bus.cmd_ready), 0);
    chk("bp_res_valid", int'(bus.res_valid), 1);
    got_q.delete();
    drain(60);
    chk("bp_drained", got_q.size(), DEPTH + 1);
    chk("bp_ready_back", int'(bus.cmd_ready), 1);

    // Occupancy 3 with push and pop on the same edge, wrapping the pointers.
    got_q.delete();
    n_acc = 0;
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_cmd();
      tick();
    end
    chk("occ_prefill", n_acc, 4);
    for (int i = 0; i < 12; i++) begin
      chk("occ_res_valid", int'(bus.res_valid), 1);
      rand_cmd();
      bus.cmd_valid = 1'b1;
      bus.res_ready = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b0;
      tick();
      chk("occ_not_full", int'(bus.cmd_ready), 1);
    end
    n_acc = 0;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_cmd();
      tick();
    end
    chk("occ_room_one", n_acc, 1);
    chk("occ_full", int'(bus.cmd_ready), 0);
    drain(80);
    chk("occ_total", got_q.size(), 17);

    // Reset while holding a result with two commands queued.
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_cmd();
      tick();
    end
    bus.cmd_valid = 1'b0;
    chk("hold_valid", int'(bus.res_valid), 1);
    chk("hold_busy", int'(busy), 1);
    do_reset();
    chk("mid_rst_valid", int'(bus.res_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_alu", int'({alu_sel, alu_a, alu_b}), 0);
    chk("mid_rst_data", int'(bus.res_data), 0);
    chk("mid_rst_ready", int'(bus.cmd_ready), 1);
    got_q.delete();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("no_stale", got_q.size(), 0);

    // Accumulator as operand B.
    got_q.delete();
    set_cmd(1, 3, 4, 0);
    bus.cmd_valid = 1'b1;
    tick();
    set_cmd(1, 1, 9, 1);
    tick();
    drain(20);
    chk("acc_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("acc_first", got_q[0], 7);
`ifdef ALU_SEQ_ACC_EN
      chk("acc_second", got_q[1], 8);
`else
      chk("acc_second", got_q[1], 10);
`endif
    end

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      bus.cmd_valid = ($urandom_range(0, 9) < 6);
      bus.res_ready = ($urandom_range(0, 1) == 1);
      rand_cmd();
      if (exp_q.size() == DEPTH + 1) chk("rnd_full_at_max", int'(bus.cmd_ready), 0);
      tick();
    end
    drain(60);
    tick();
    chk("end_busy", int'(busy), 0);
    chk("end_ready", int'(bus.cmd_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command sequencer directly upstream of the 5-bit AND/ADD/OR/XOR ALU stage. Accepts operation commands over a valid/ready interface and buffers them in a small FIFO. Issues one command at a time to the ALU's `Select`/`A`/`B` inputs, then registers the ALU's `Sum` and presents it downstream with a valid/ready handshake. An optional accumulator lets a command take the previous result as operand B.

## Interface
- `DEPTH`, 4: command FIFO entries; must be a power of two, at least 2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on `clk`.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO not full; command accepted when `cmd_valid && cmd_ready` at an edge.
- `cmd_op`  in  2  00 AND, 01 ADD, 10 OR, 11 XOR.
- `cmd_a`, `cmd_b`  in  5 each  operands.
- `cmd_use_acc`  in  1  use accumulator as operand B; present only with `ALU_SEQ_ACC_EN`.
- `alu_sel`  out  2  driven to the ALU `Select` input.
- `alu_a`, `alu_b`  out  5 each  driven to the ALU `A`/`B` inputs.
- `alu_sum`  in  5  ALU `Sum` result, combinational from `alu_*`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream accepts; transfer when both are high at an edge.
- `res_data`  out  5  registered result.
- `res_op`  out  2  op that produced `res_data`.
- `busy`  out  1  high when the FSM is not IDLE or the FIFO is not empty.

## Operation
- FIFO stores `{op, a, b, use_acc}`. Pointers wrap modulo `DEPTH`, with one extra bit for full/empty. There is no bypass: a command pushed at edge N is poppable at edge N+1.
- FSM states:
  - **IDLE**: if the FIFO is not empty, pop the head, load it into the `alu_*` registers, and go to ISSUE.
  - **ISSUE**: the ALU settles combinationally. At the edge, capture `alu_sum` into `res_data`, set `res_valid=1`, go to HOLD.
  - **HOLD**: `res_valid=1`. On `res_ready`:
    - if the FIFO is not empty, pop, reload `alu_*`, go to ISSUE (`res_valid` falls the same edge);
    - otherwise go to IDLE.
  - **HOLD** without `res_ready`: `res_data`, `res_op` and `alu_*` hold.
- Arithmetic is the ALU's: ADD wraps modulo 32 and the carry is discarded. The sequencer does no arithmetic itself.
- Push and pop in the same cycle are legal. Occupancy is unchanged, and the count is computed from the pointers.
- `cmd_ready` depends only on FIFO fullness, never on `cmd_valid`.
- `alu_*` change only on pop or reset.
- Reset at any time:
  - FIFO flushed, FSM to IDLE;
  - `res_valid=0`, `res_data=0`, `res_op=0`;
  - `alu_sel=0`, `alu_a=0`, `alu_b=0`;
  - accumulator 0;
  - `cmd_ready=1` in the first cycle after reset;
  - any in-flight command is discarded.

## Timing
- Latency with an empty FIFO: command accepted at edge N, popped at N+1, `res_valid` high after N+2.
- Back-to-back throughput: one result per 2 cycles when `res_ready` is held high.
- Maximum commands outstanding: `DEPTH` in the FIFO plus 1 in ISSUE/HOLD.
- All outputs are registered. No combinational path exists from `cmd_*` or `res_ready` to any output.

## Configuration
- `ALU_SEQ_ACC_EN` defined:
  - 5-bit accumulator register, loaded with `res_data`'s new value at every ISSUE capture;
  - `cmd_use_acc` port exists and is stored in the FIFO;
  - on pop with `use_acc=1`, `alu_b` is taken from the accumulator instead of `b`. The accumulator is always current because issue is serial.
- Undefined: no accumulator, no `cmd_use_acc` port, and `alu_b` is always `b`.

## Structure
- Package `alu_seq_pkg`:
  - `WIDTH=5`;
  - op constants `OP_AND`, `OP_ADD`, `OP_OR`, `OP_XOR`;
  - FSM state enum `{IDLE, ISSUE, HOLD}`;
  - FIFO entry struct type.
- Sub-module `alu_cmd_fifo`: parameterised synchronous FIFO providing push, pop, full, empty and head data.
- The ALU itself is instantiated by the parent, not inside this block.

## Test plan
- Reset, then ADD a=20, b=15 with `res_ready=1`: `res_valid` two edges after acceptance, `res_data=3`, `res_op=01`.
- AND 10110 & 01100, then XOR 10110 ^ 01100 back-to-back: results 00100 then 11010, one result every 2 cycles.
- Hold `res_ready=0` and push commands continuously: exactly `DEPTH+1` (5) accepted, then `cmd_ready=0`. Release `res_ready`: all results drain in order and `cmd_ready` returns high.
- Push/pop in the same cycle at occupancy 3: occupancy stays 3, order is preserved, and the pointers wrap correctly over 10+ commands.
- Assert `reset` in HOLD with 2 commands queued: the next cycle shows `res_valid=0`, `busy=0`, `alu_*=0`, and no stale results afterwards.
- With `ALU_SEQ_ACC_EN`: ADD 3+4 gives 7, then ADD a=1 with `use_acc=1` and b=9 gives 8 (b ignored). Without the macro, the same first command gives 7.
